// File: rtl/intc_pkg.sv
// Shared definitions for the multi-hart interrupt controller: register offsets,
// access FSM encoding and fixed read-back patterns.
package intc_pkg;

    localparam logic [7:0] OFF_ISR = 8'h00;
    localparam logic [7:0] OFF_IER = 8'h08;
    localparam logic [7:0] OFF_IAR = 8'h0C;
    localparam logic [7:0] OFF_SIE = 8'h10;
    localparam logic [7:0] OFF_CIE = 8'h14;
    localparam logic [7:0] OFF_IVR = 8'h18;
    localparam logic [7:0] OFF_MER = 8'h1C;
    localparam logic [7:0] OFF_ILR = 8'h24;

    localparam logic [31:0] IVR_NONE = 32'hFFFF_FFFF;
    localparam logic [31:0] BAD_READ = 32'hDEAD_BEAF;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Registers banked per hart; an out-of-range hart index makes these inaccessible.
    function automatic logic is_per_hart(input logic [7:0] off);
        return (off == OFF_IER) || (off == OFF_SIE) || (off == OFF_CIE) ||
               (off == OFF_IVR) || (off == OFF_MER);
    endfunction

endpackage

// File: rtl/intc_if.sv
// Aquila device-port bundle: one strobe-started access, completed by a data_ready pulse.
interface intc_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  strobe;
    logic [ADDR_W-1:0]     addr;
    logic                  rw;
    logic [DATA_W/8-1:0]   byte_enable;
    logic [DATA_W-1:0]     core2dev_data;
    logic                  data_ready;
    logic [DATA_W-1:0]     dev2core_data;

    modport master (
        output strobe, addr, rw, byte_enable, core2dev_data,
        input  data_ready, dev2core_data
    );

    modport slave (
        input  strobe, addr, rw, byte_enable, core2dev_data,
        output data_ready, dev2core_data
    );
endinterface

// File: rtl/intc_prio_enc.sv
// Combinational lowest-set-bit finder; idx is only meaningful when valid is high.
module intc_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] vec,
    output logic         valid,
    output logic [4:0]   idx
);

    always_comb begin
        valid = |vec;
        idx   = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = 5'(i);
        end
    end

endmodule

// File: rtl/intc_mp.sv
// Multi-hart interrupt controller: latched edge/level sources, per-hart enable and
// master enable, vector lookup, and a fixed-latency device-port access FSM.
module intc_mp
    import intc_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int NUM_OF_IRQS        = 8,
    parameter int NUM_OF_HARTS       = 2,
    parameter int AXI_LANTENCY       = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    intc_if.slave                   M_DEVICE,
    input  logic [NUM_OF_IRQS-1:0]  intr,
    output logic [NUM_OF_HARTS-1:0] irq
);

    localparam int N = NUM_OF_IRQS;
    localparam int H = NUM_OF_HARTS;

    state_t      state, state_nx;
    logic [7:0]  cnt;
    logic [7:0]  off_q;
    logic [3:0]  h_q;
    logic        rw_q;
    logic [N-1:0] wd_q;
    logic        ready_q;
    logic [31:0] rdata_q;

    logic [N-1:0]         isr, ilr, intr_q;
    logic [H-1:0][N-1:0]  ier;
    logic [H-1:0]         mer;
    logic [H-1:0]         ivr_vld;
    logic [H-1:0][4:0]    ivr_idx;

    logic         wr_commit;
    logic         hart_ok;
    logic [N-1:0] iar_clr;
    logic [N-1:0] rise;
    logic [N-1:0] ier_h;
    logic         mer_h;
    logic         ivr_vld_h;
    logic [4:0]   ivr_idx_h;
    logic [31:0]  rdata;

    // Only full-word accesses at offsets within the low 12 address bits are decoded.
    logic unused;
    assign unused = ^{M_DEVICE.byte_enable, M_DEVICE.addr, M_DEVICE.core2dev_data};

    function automatic logic [31:0] ext(input logic [N-1:0] v);
        ext = '0;
        ext[N-1:0] = v;
    endfunction

    assign M_DEVICE.data_ready    = ready_q;
    assign M_DEVICE.dev2core_data = rdata_q;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (M_DEVICE.strobe) state_nx = BUSY;
            BUSY:    if (cnt == 8'(AXI_LANTENCY - 1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            off_q   <= '0;
            h_q     <= '0;
            rw_q    <= 1'b0;
            wd_q    <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= (state == BUSY) ? cnt + 8'd1 : 8'd0;
            ready_q <= (state == DONE);
            if (state == IDLE && M_DEVICE.strobe) begin
                off_q <= M_DEVICE.addr[7:0];
                h_q   <= M_DEVICE.addr[11:8];
                rw_q  <= M_DEVICE.rw;
                wd_q  <= M_DEVICE.core2dev_data[N-1:0];
            end
            if (state == DONE && !rw_q) rdata_q <= rdata;
        end
    end

    for (genvar g = 0; g < H; g++) begin : g_enc
        intc_prio_enc #(.N(N)) u_enc (
            .vec   (isr & ier[g]),
            .valid (ivr_vld[g]),
            .idx   (ivr_idx[g])
        );
    end

    always_comb begin
        hart_ok   = int'(h_q) < H;
        ier_h     = '0;
        mer_h     = 1'b0;
        ivr_vld_h = 1'b0;
        ivr_idx_h = '0;
        for (int g = 0; g < H; g++) begin
            if (h_q == 4'(g)) begin
                ier_h     = ier[g];
                mer_h     = mer[g];
                ivr_vld_h = ivr_vld[g];
                ivr_idx_h = ivr_idx[g];
            end
        end
        case (off_q)
            OFF_ISR:                   rdata = ext(isr);
            OFF_IER:                   rdata = ext(ier_h);
            OFF_IAR, OFF_SIE, OFF_CIE: rdata = '0;
            OFF_IVR:                   rdata = ivr_vld_h ? {27'd0, ivr_idx_h} : IVR_NONE;
            OFF_MER:                   rdata = {31'd0, mer_h};
            OFF_ILR:                   rdata = ext(ilr);
            default:                   rdata = BAD_READ;
        endcase
        if (is_per_hart(off_q) && !hart_ok) rdata = BAD_READ;
    end

    assign wr_commit = (state == DONE) && rw_q;
    assign iar_clr   = (wr_commit && off_q == OFF_IAR) ? wd_q : '0;
    assign rise      = intr & ~intr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            isr    <= '0;
            ilr    <= '0;
            intr_q <= '0;
            ier    <= '0;
            mer    <= '0;
            irq    <= '0;
        end else begin
            intr_q <= intr;
            // Edge bits: a new rising edge beats a same-cycle clear. Level bits track intr.
            isr    <= (ilr & ((isr & ~iar_clr) | rise)) | (~ilr & intr);
            if (wr_commit && off_q == OFF_ILR) ilr <= wd_q;
            for (int g = 0; g < H; g++) begin
                if (wr_commit && h_q == 4'(g)) begin
                    if (off_q == OFF_IER) ier[g] <= wd_q;
                    if (off_q == OFF_SIE) ier[g] <= ier[g] | wd_q;
                    if (off_q == OFF_CIE) ier[g] <= ier[g] & ~wd_q;
                    if (off_q == OFF_MER) mer[g] <= wd_q[0];
                end
                irq[g] <= mer[g] & |(isr & ier[g]);
            end
        end
    end

endmodule

// File: tb/tb_intc_mp.sv
// Directed bench for intc_mp: register access latency, edge/level capture, per-hart masking.
module tb_intc_mp;

    localparam int LAT = 10;
    localparam int N   = 8;
    localparam int H   = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] intr;
    logic [H-1:0] irq;

    intc_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    intc_mp #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (32),
        .NUM_OF_IRQS        (N),
        .NUM_OF_HARTS       (H),
        .AXI_LANTENCY       (LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .M_DEVICE (bus),
        .intr     (intr),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           failures = 0;
    int           lat;
    int           pulses;
    logic [31:0]  rd;
    logic         rdy_after;
    logic [H-1:0] irq_rdy, irq_after;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // lat counts clock edges from strobe assertion up to the edge raising data_ready.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.strobe = 1'b1; bus.rw = w; bus.addr = a; bus.core2dev_data = d;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.strobe = 1'b0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.data_ready && lat < 100);
        if (!bus.data_ready) chk("access_timeout", 32'd0, 32'd1);
        rd      = bus.dev2core_data;
        irq_rdy = irq;
        @(posedge clk); #1;
        rdy_after = bus.data_ready;
        irq_after = irq;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; intr = '0;
        bus.strobe = 1'b0; bus.rw = 1'b0; bus.addr = '0;
        bus.byte_enable = 4'hF; bus.core2dev_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.data_ready), 32'd0);
        chk("rst_irq",   32'(irq), 32'd0);
        chk("rst_rdata", bus.dev2core_data, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // reset values and access latency
        access(1'b0, 32'h000, 0); chk("t1_isr", rd, 32'h0);
        chk("t1_lat", 32'(lat), 32'(LAT + 2));
        chk("t1_pulse_width", 32'(rdy_after), 32'd0);
        access(1'b0, 32'h018, 0); chk("t1_ivr0", rd, 32'hFFFF_FFFF);
        chk("t1_lat_ivr", 32'(lat), 32'(LAT + 2));
        access(1'b0, 32'h01C, 0); chk("t1_mer0", rd, 32'h0);
        access(1'b0, 32'h004, 0); chk("bad_offset", rd, 32'hDEAD_BEAF);

        // edge capture on hart 1
        access(1'b1, 32'h024, 32'h1FF);
        access(1'b0, 32'h024, 0); chk("t2_ilr", rd, 32'hFF);
        access(1'b1, 32'h108, 32'h0C);
        access(1'b1, 32'h11C, 32'hFFFF_FFFF);
        access(1'b0, 32'h11C, 0); chk("t2_mer1", rd, 32'h1);
        @(negedge clk) intr = 8'h08;
        @(negedge clk) intr = 8'h00;
        @(posedge clk); #1;
        chk("t2_irq", 32'(irq), 32'h2);
        access(1'b0, 32'h000, 0); chk("t2_isr", rd, 32'h08);
        access(1'b0, 32'h118, 0); chk("t2_ivr1", rd, 32'h3);
        access(1'b0, 32'h018, 0); chk("t2_ivr0", rd, 32'hFFFF_FFFF);
        access(1'b1, 32'h10C, 32'h08);
        chk("t2_irq_at_commit", 32'(irq_rdy), 32'h2);
        chk("t2_irq_after", 32'(irq_after), 32'h0);
        access(1'b0, 32'h000, 0); chk("t2_isr_clr", rd, 32'h0);

        // level mode on hart 0
        access(1'b1, 32'h024, 32'h0);
        @(negedge clk) intr = 8'h01;
        access(1'b1, 32'h008, 32'h1);
        access(1'b1, 32'h01C, 32'h1);
        chk("t3_irq", 32'(irq), 32'h1);
        access(1'b1, 32'h00C, 32'h1);
        chk("t3_iar_level", 32'(irq), 32'h1);
        @(negedge clk) intr = 8'h00;
        @(posedge clk); #1; chk("t3_drop_1", 32'(irq), 32'h1);
        @(posedge clk); #1; chk("t3_drop_2", 32'(irq), 32'h0);

        // edge arriving on the same edge as an IAR commit
        access(1'b1, 32'h024, 32'hFF);
        @(negedge clk) intr = 8'h04;
        @(negedge clk) intr = 8'h00;
        access(1'b0, 32'h000, 0); chk("t4_pend", rd, 32'h04);
        @(negedge clk);
        bus.strobe = 1'b1; bus.rw = 1'b1; bus.addr = 32'h00C; bus.core2dev_data = 32'h04;
        @(posedge clk);
        @(negedge clk) bus.strobe = 1'b0;
        repeat (LAT) @(posedge clk);
        @(negedge clk) intr = 8'h04;
        @(posedge clk); #1;
        chk("t4_commit_edge", 32'(bus.data_ready), 32'd1);
        @(negedge clk) intr = 8'h00;
        access(1'b0, 32'h000, 0); chk("t4_set_wins", rd, 32'h04);
        access(1'b1, 32'h00C, 32'h04);
        access(1'b0, 32'h000, 0); chk("t4_clear", rd, 32'h0);

        // set/clear enable and out-of-range hart
        access(1'b1, 32'h010, 32'h05);
        access(1'b1, 32'h014, 32'h01);
        access(1'b0, 32'h008, 0); chk("t5_ier0", rd, 32'h04);
        access(1'b1, 32'h510, 32'hFF);
        access(1'b0, 32'h508, 0); chk("t5_bad_hart", rd, 32'hDEAD_BEAF);
        access(1'b0, 32'h008, 0); chk("t5_ier0_kept", rd, 32'h04);
        access(1'b0, 32'h108, 0); chk("t5_ier1_kept", rd, 32'h0C);

        // reset in the middle of a write
        @(negedge clk);
        bus.strobe = 1'b1; bus.rw = 1'b1; bus.addr = 32'h008; bus.core2dev_data = 32'hFF;
        @(posedge clk);
        @(negedge clk) bus.strobe = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        pulses = 0;
        repeat (LAT + 5) begin
            @(posedge clk); #1;
            if (bus.data_ready) pulses++;
        end
        chk("t6_no_ready", 32'(pulses), 32'd0);
        access(1'b0, 32'h008, 0); chk("t6_ier0", rd, 32'h0);

        // strobe while busy is ignored
        @(negedge clk);
        bus.strobe = 1'b1; bus.rw = 1'b0; bus.addr = 32'h000;
        @(posedge clk);
        @(negedge clk) bus.strobe = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) bus.strobe = 1'b1;
        @(negedge clk) bus.strobe = 1'b0;
        pulses = 0;
        repeat (3 * LAT) begin
            @(posedge clk); #1;
            if (bus.data_ready) pulses++;
        end
        chk("t6_one_ready", 32'(pulses), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
